// File: rtl/memctrl_pkg.sv
// Shared types and constants for the byte-wide memory controller.
// Optional feature macro used by this slice: MEMCTRL_RESUME_EN.
package memctrl_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;
  localparam int WORD_BYTES = WORD_W / BYTE_W;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } fetch_state_t;

  // The reserved encoding 2'b11 behaves like idle.
  function automatic logic is_mem_req(input logic [1:0] rw);
    return (rw == RW_READ) || (rw == RW_WRITE);
  endfunction

endpackage

// File: rtl/memctrl_if.sv
// Pipeline-side bus of memctrl: the IF fetch handshake and the MEM byte port.
interface memctrl_if;

  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_done_o;
  logic [1:0]  mem_rw_i;
  logic [31:0] mem_addr_i;
  logic [7:0]  mem_data_i;
  logic [7:0]  mem_data_o;

  modport master (
    output if_req_i, if_addr_i, mem_rw_i, mem_addr_i, mem_data_i,
    input  if_data_o, if_done_o, mem_data_o
  );

  modport slave (
    input  if_req_i, if_addr_i, mem_rw_i, mem_addr_i, mem_data_i,
    output if_data_o, if_done_o, mem_data_o
  );

endinterface

// File: rtl/memctrl_fetch.sv
// Four-byte instruction fetch engine; yields the RAM port whenever MEM is busy.
// MEMCTRL_RESUME_EN: preemption pauses the fetch instead of restarting it.
module memctrl_fetch
  import memctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        mem_busy,
  input  logic [7:0]  ram_din,
  output logic [31:0] if_data,
  output logic        if_done,
  output logic        issue_valid,
  output logic [31:0] issue_addr
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  base_reg, base_next;
  logic [2:0]   issue_idx_reg, issue_idx_next;
  logic [2:0]   recv_idx_reg, recv_idx_next;
  logic         inflight_reg, inflight_next;
  logic [31:0]  asm_reg, asm_next;
  logic [31:0]  data_reg, data_next;
  logic [31:0]  capt_word;
  logic         restart;

  // Word as it looks once the arriving byte lands in lane recv_idx.
  generate
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign capt_word[gi*BYTE_W +: BYTE_W] =
        (recv_idx_reg == 3'(gi)) ? ram_din : asm_reg[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

`ifdef MEMCTRL_RESUME_EN
  assign restart = 1'b0;
`else
  assign restart = mem_busy;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      issue_idx_reg <= '0;
      recv_idx_reg  <= '0;
      inflight_reg  <= 1'b0;
      asm_reg       <= '0;
      data_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      base_reg      <= base_next;
      issue_idx_reg <= issue_idx_next;
      recv_idx_reg  <= recv_idx_next;
      inflight_reg  <= inflight_next;
      asm_reg       <= asm_next;
      data_reg      <= data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    base_next      = base_reg;
    issue_idx_next = issue_idx_reg;
    recv_idx_next  = recv_idx_reg;
    inflight_next  = 1'b0;
    asm_next       = asm_reg;
    data_next      = data_reg;
    issue_valid    = 1'b0;
    if_done        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (if_req) begin
          state_next     = FETCH;
          base_next      = if_addr;
          issue_idx_next = '0;
          recv_idx_next  = '0;
          asm_next       = '0;
        end
      end
      FETCH: begin
        if (!if_req || restart) begin
          if (!if_req) state_next = IDLE;
          issue_idx_next = '0;
          recv_idx_next  = '0;
          asm_next       = '0;
        end else begin
          // A byte issued just before a MEM cycle still lands during it.
          if (inflight_reg) begin
            asm_next      = capt_word;
            recv_idx_next = recv_idx_reg + 3'd1;
            if (recv_idx_reg == 3'(WORD_BYTES - 1)) begin
              data_next  = capt_word;
              state_next = DONE;
            end
          end
          if (!mem_busy && (issue_idx_reg < 3'(WORD_BYTES))) begin
            issue_valid    = 1'b1;
            issue_idx_next = issue_idx_reg + 3'd1;
            inflight_next  = 1'b1;
          end
        end
      end
      DONE: begin
        if_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign issue_addr = base_reg + {29'd0, issue_idx_reg};
  assign if_data    = data_reg;

endmodule

// File: rtl/memctrl.sv
// Single-port RAM arbiter: MEM byte requests win, the fetch engine uses free cycles.
// Build option MEMCTRL_RESUME_EN selects pause/resume on preemption (else restart).
module memctrl
  import memctrl_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  memctrl_if.slave          bus,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  logic        mem_req;
  logic        issue_valid;
  logic [31:0] issue_addr;
  logic        unused_addr_bits;

  assign mem_req = is_mem_req(bus.mem_rw_i);

  memctrl_fetch u_fetch (
    .clk         (clk),
    .rst         (rst),
    .if_req      (bus.if_req_i),
    .if_addr     (bus.if_addr_i),
    .mem_busy    (mem_req),
    .ram_din     (ram_din),
    .if_data     (bus.if_data_o),
    .if_done     (bus.if_done_o),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr)
  );

  always_comb begin
    ram_a    = '0;
    ram_wr   = 1'b0;
    ram_dout = '0;
    if (mem_req) begin
      ram_a    = bus.mem_addr_i[ADDR_W-1:0];
      ram_wr   = (bus.mem_rw_i == RW_WRITE);
      ram_dout = bus.mem_data_i;
    end else if (issue_valid) begin
      ram_a = issue_addr[ADDR_W-1:0];
    end
  end

  assign bus.mem_data_o = ram_din;

  // Addresses wrap onto the RAM; the high bits are intentionally dropped.
  assign unused_addr_bits = ^{bus.mem_addr_i[31:ADDR_W], issue_addr[31:ADDR_W]};

endmodule

// File: tb/tb_memctrl.sv
// Directed self-checking bench for memctrl with a synchronous byte-RAM model.
module tb_memctrl;
  import memctrl_pkg::*;

  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;

  logic              load_en = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [7:0]        load_data = '0;
  logic [7:0]        ram_mem [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_fail   = 0;

  memctrl_if bus();

  memctrl #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .ram_a    (ram_a),
    .ram_wr   (ram_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_en) ram_mem[load_addr] <= load_data;
    else if (ram_wr) ram_mem[ram_a] <= ram_dout;
    ram_din <= ram_mem[ram_a];
  end

  task automatic load_word(input logic [ADDR_W-1:0] base, input logic [31:0] word);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      load_en   = 1'b1;
      load_addr = base + ADDR_W'(i);
      load_data = word[i*8 +: 8];
    end
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // Runs one fetch; cycle 1 is the cycle after the accepting edge.
  task automatic run_fetch(input logic [31:0] addr, input int mem_cyc, input int budget,
                           output int done_cyc, output int pulses, output logic [7:0] mem_rd);
    @(posedge clk); #1;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = addr;
    @(posedge clk);
    done_cyc = 0;
    pulses   = 0;
    mem_rd   = '0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      #1;
      if (cyc == mem_cyc) begin
        bus.mem_rw_i   = RW_READ;
        bus.mem_addr_i = 32'h20;
      end else begin
        bus.mem_rw_i = RW_IDLE;
      end
      @(negedge clk);
      if (cyc == mem_cyc + 1) mem_rd = bus.mem_data_o;
      if (bus.if_done_o) begin
        pulses++;
        if (done_cyc == 0) done_cyc = cyc;
        bus.if_req_i = 1'b0;
      end
      @(posedge clk);
    end
    #1;
    bus.if_req_i = 1'b0;
    $display("fetch addr=%h data=%h done_cycle=%0d pulses=%0d", addr, bus.if_data_o, done_cyc, pulses);
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++; if (bus.if_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 00000000", bus.if_data_o); end
    n_checks++; if (bus.if_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.if_done_o); end
    n_checks++; if (ram_a !== '0 || ram_wr !== 1'b0 || ram_dout !== 8'h0) begin
      n_fail++; $display("FAIL reset_ram: got a=%h wr=%b dout=%h want 0 0 0", ram_a, ram_wr, ram_dout);
    end
    $display("reset state checked");
  endtask

  task automatic test_mem_write;
    @(posedge clk); #1;
    bus.mem_rw_i = RW_WRITE; bus.mem_addr_i = 32'h20; bus.mem_data_i = 8'hAB;
    @(negedge clk);
    n_checks++; if (ram_wr !== 1'b1 || ram_a !== 17'h20 || ram_dout !== 8'hAB) begin
      n_fail++; $display("FAIL mem_write_port: got wr=%b a=%h dout=%h want 1 00020 ab", ram_wr, ram_a, ram_dout);
    end
    @(posedge clk); #1;
    bus.mem_rw_i = RW_READ; bus.mem_addr_i = 32'h0002_0020; bus.mem_data_i = 8'h00;
    @(negedge clk);
    n_checks++; if (ram_wr !== 1'b0 || ram_a !== 17'h20) begin
      n_fail++; $display("FAIL mem_read_port: got wr=%b a=%h want 0 00020", ram_wr, ram_a);
    end
    @(posedge clk); #1;
    bus.mem_rw_i = 2'b11; bus.mem_addr_i = 32'h55;
    @(negedge clk);
    n_checks++; if (bus.mem_data_o !== 8'hAB) begin n_fail++; $display("FAIL mem_read_data: got %h want ab", bus.mem_data_o); end
    n_checks++; if (ram_a !== '0 || ram_wr !== 1'b0) begin
      n_fail++; $display("FAIL mem_reserved: got a=%h wr=%b want 0 0", ram_a, ram_wr);
    end
    @(posedge clk); #1;
    bus.mem_rw_i = RW_IDLE; bus.mem_addr_i = '0;
    $display("mem write/read 0x20 checked");
  endtask

  task automatic test_fetch;
    int d, p; logic [7:0] m;
    run_fetch(32'h100, 0, 12, d, p, m);
    n_checks++; if (bus.if_data_o !== 32'h0000_0513) begin n_fail++; $display("FAIL fetch_data: got %h want 00000513", bus.if_data_o); end
    n_checks++; if (d !== 6) begin n_fail++; $display("FAIL fetch_latency: got %0d want 6", d); end
    n_checks++; if (p !== 1) begin n_fail++; $display("FAIL fetch_pulse: got %0d want 1", p); end
  endtask

  task automatic test_preempt;
    int d, p, want_d; logic [7:0] m;
`ifdef MEMCTRL_RESUME_EN
    want_d = 7;
`else
    want_d = 9;
`endif
    run_fetch(32'h300, 3, 14, d, p, m);
    n_checks++; if (bus.if_data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL preempt_data: got %h want deadbeef", bus.if_data_o); end
    n_checks++; if (d !== want_d) begin n_fail++; $display("FAIL preempt_latency: got %0d want %0d", d, want_d); end
    n_checks++; if (p !== 1) begin n_fail++; $display("FAIL preempt_pulse: got %0d want 1", p); end
    n_checks++; if (m !== 8'hAB) begin n_fail++; $display("FAIL preempt_mem_read: got %h want ab", m); end
  endtask

  task automatic test_abort;
    int d, p, pulses; logic [7:0] m;
    @(posedge clk); #1;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h200;
    repeat (3) @(posedge clk);
    #1;
    bus.if_req_i = 1'b0;
    pulses = 0;
    for (int cyc = 3; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (bus.if_done_o) pulses++;
      if (cyc == 4) begin
        n_checks++; if (ram_a !== '0) begin n_fail++; $display("FAIL abort_idle_port: got %h want 0", ram_a); end
      end
      @(posedge clk);
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses); end
    n_checks++; if (bus.if_data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL abort_hold: got %h want deadbeef", bus.if_data_o); end
    $display("abort at 0x200 checked");
    run_fetch(32'h200, 0, 12, d, p, m);
    n_checks++; if (bus.if_data_o !== 32'h0010_0093) begin n_fail++; $display("FAIL refetch_data: got %h want 00100093", bus.if_data_o); end
    n_checks++; if (d !== 6) begin n_fail++; $display("FAIL refetch_latency: got %0d want 6", d); end
  endtask

  task automatic test_reset_midfetch;
    int pulses;
    @(posedge clk); #1;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.if_data_o !== 32'h0 || bus.if_done_o !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got data=%h done=%b want 0 0", bus.if_data_o, bus.if_done_o);
    end
    n_checks++; if (ram_a !== '0 || ram_wr !== 1'b0) begin
      n_fail++; $display("FAIL midreset_ram: got a=%h wr=%b want 0 0", ram_a, ram_wr);
    end
    bus.if_req_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (bus.if_done_o) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses want 0", pulses); end
    $display("reset mid-fetch checked");
  endtask

  initial begin
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = '0;
    bus.mem_rw_i   = RW_IDLE;
    bus.mem_addr_i = '0;
    bus.mem_data_i = '0;
    test_reset;
    load_word(17'h100, 32'h0000_0513);
    load_word(17'h200, 32'h0010_0093);
    load_word(17'h300, 32'hDEAD_BEEF);
    @(negedge clk);
    rst = 1'b1;
    test_mem_write;
    test_fetch;
    test_preempt;
    test_abort;
    test_reset_midfetch;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memctrl.md
# memctrl

Byte-wide memory controller between the pipeline and the single-port synchronous RAM. It arbitrates one RAM port between the MEM stage's per-byte load/store requests and a 4-byte instruction-fetch engine serving IF. MEM always has priority: its byte requests pass straight through to the RAM, and the fetch engine pauses around them. Fetched bytes are assembled into a little-endian 32-bit instruction word.

## Interface
- ADDR_W, 17, RAM address width; upper address bits are dropped.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- if_req_i  in  1  IF requests an instruction word; held until if_done_o.
- if_addr_i  in  32  byte address of the instruction; sampled when a request is accepted.
- if_data_o  out  32  assembled instruction, little-endian.
- if_done_o  out  1  one-cycle pulse; if_data_o is valid in the same cycle.
- mem_rw_i  in  2  MEM request: 00 idle, 01 read byte, 10 write byte, 11 reserved (treated as 00).
- mem_addr_i  in  32  MEM byte address.
- mem_data_i  in  8  MEM write byte.
- mem_data_o  out  8  MEM read byte; valid in the cycle after the request cycle.
- ram_din  in  8  RAM read data; valid the cycle after its address was presented.
- ram_dout  out  8  RAM write data.
- ram_a  out  ADDR_W  RAM address.
- ram_wr  out  1  1 = write, 0 = read.

## Operation
- RAM port is combinational from the selected requester:
  - mem_rw_i in {01, 10}: ram_a = mem_addr_i[ADDR_W-1:0], ram_wr = (mem_rw_i == 10), ram_dout = mem_data_i.
  - else, fetch engine issuing: ram_a = fetch_base + issue_idx, ram_wr = 0.
  - else: ram_a = 0, ram_wr = 0, ram_dout = 0.
- mem_data_o = ram_din at all times (pass-through).
- Fetch FSM states: IDLE, FETCH, DONE.
  - IDLE: if_req_i = 1 → latch fetch_base = if_addr_i, set issue_idx = 0, recv_idx = 0, go to FETCH.
  - FETCH, no MEM request and issue_idx < 4: issue byte issue_idx, increment issue_idx (3-bit), set inflight = 1.
  - FETCH, MEM request present: issue nothing; set inflight = 0 for the next cycle.
  - Capture: on every edge where inflight was 1, write ram_din into byte lane recv_idx of the assembly register and increment recv_idx.
  - FETCH, capture of byte 3 → DONE.
  - DONE: if_done_o = 1 for one cycle, if_data_o holds the assembled word, then go to IDLE.
- The byte issued in the cycle before a MEM cycle is still captured; its data arrives during the MEM cycle.
- MEM read data arriving the following cycle is never captured, because inflight = 0.
- if_req_i = 0 in FETCH aborts the fetch: return to IDLE, no if_done_o, assembled bytes discarded.
- if_data_o holds its last value until the next DONE.

## Timing
- Reset (rst low, asynchronous):
  - if_data_o = 0, if_done_o = 0, state = IDLE, counters = 0, inflight = 0.
  - RAM outputs follow the combinational idle values.
  - Reset mid-fetch discards the fetch and never produces a done pulse.
- Uncontended fetch latency: request accepted at edge E0; byte k issued in cycle k+1; captured at edge E(k+2); if_done_o high in the cycle after E5.
- Each MEM cycle during a fetch adds exactly one cycle of latency (with MEMCTRL_RESUME_EN).
- MEM read: mem_rw_i = 01 in cycle c → mem_data_o valid in cycle c+1.
- MEM write: the RAM write happens at the end of cycle c.
- A new if_req_i is accepted no earlier than the cycle after DONE; there is no back-to-back overlap.

## Configuration
- MEMCTRL_RESUME_EN defined: a MEM preemption pauses the fetch; it resumes at the current issue_idx with all captured bytes kept.
- Undefined: the first MEM cycle during FETCH resets issue_idx, recv_idx and the assembly register to 0. Byte 0 is reissued in the first free cycle after the MEM request ends. The capture in the MEM cycle is dropped.

## Structure
- Package memctrl_pkg:
  - rw encodings RW_IDLE = 2'b00, RW_READ = 2'b01, RW_WRITE = 2'b10.
  - fetch state enum {IDLE, FETCH, DONE}.
  - byte and word width constants.
- Sub-module memctrl_fetch: the fetch FSM, its counters and the assembly register.
- Top level: the combinational RAM-port mux and the MEM pass-through.

## Test plan
- Uncontended fetch: RAM[0x100..0x103] = 13,05,00,00, req at 0x100 → if_data_o = 0x00000513, done 5 edges after accept, one-cycle pulse.
- MEM write: rw = 10, addr 0x20, data 0xAB → ram_wr = 1, ram_a = 0x20 same cycle; later MEM read of 0x20 → mem_data_o = 0xAB next cycle.
- Preemption: MEM read in cycle 3 of a fetch → word still correct; done one edge later (RESUME_EN), or restarted from byte 0 (undefined).
- Abort: if_req_i dropped after byte 1 → no done pulse; FSM in IDLE; next request at 0x200 returns the correct word.
- Reset: rst low mid-fetch → all outputs 0 immediately; no done pulse after release.
